mul_dispatch: RTL

MUL_DISPATCH -- requirements
Module: mul_dispatch

---
 rtl/mul_dispatch.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mul_dispatch.sv
// Dispatches tile-multiply jobs to NUM_UNITS units and returns completions through one output register.
// Build option: define MUL_DISPATCH_RR_EN for round-robin dispatch; otherwise the lowest-index free unit wins.
module mul_dispatch #(
  parameter int NUM_UNITS = 3,
  parameter int TAG_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 job_valid,
  input  logic [TAG_W-1:0]     job_tag,
  output logic                 job_ready,
  output logic [NUM_UNITS-1:0] unit_start,
  output logic [TAG_W-1:0]     unit_tag,
  input  logic [NUM_UNITS-1:0] unit_done,
  output logic                 res_valid,
  output logic [TAG_W-1:0]     res_tag,
  output logic [2:0]           res_unit,
  input  logic                 res_ready,
  output logic                 idle,
  output logic                 err
);

  logic [NUM_UNITS-1:0] busy;
  logic [NUM_UNITS-1:0] slot_full;
  logic [NUM_UNITS-1:0] avail;
  logic [NUM_UNITS-1:0] start_r;
  logic [NUM_UNITS-1:0] disp_onehot;
  logic [TAG_W-1:0]     run_tag  [NUM_UNITS];
  logic [TAG_W-1:0]     slot_tag [NUM_UNITS];
  logic [TAG_W-1:0]     unit_tag_r;
  logic [TAG_W-1:0]     res_tag_r;
  logic [TAG_W-1:0]     res_sel_tag;
  logic [2:0]           res_unit_r;
  logic [2:0]           res_sel;
  logic [2:0]           disp_idx;
  logic                 disp_found;
  logic                 res_any;
  logic                 res_valid_r;
  logic                 err_r;
  logic                 accept;
  logic                 load;

`ifdef MUL_DISPATCH_RR_EN
  logic [2:0] rr_ptr;
  logic [3:0] cand;
`endif

  assign avail     = ~busy & ~slot_full;
  assign job_ready = |avail;
  assign accept    = job_valid && job_ready;
  assign load      = !res_valid_r || res_ready;

  always_comb begin : dispatch_pick
    disp_found = 1'b0;
    disp_idx   = '0;
`ifdef MUL_DISPATCH_RR_EN
    cand = '0;
    // Search begins at rr_ptr (the unit after the last dispatch) and wraps.
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      cand = {1'b0, rr_ptr} + 4'(i);
      if (cand >= 4'(NUM_UNITS)) cand = cand - 4'(NUM_UNITS);
      for (int unsigned j = 0; j < NUM_UNITS; j++) begin
        if (!disp_found && cand == 4'(j) && avail[j]) begin
          disp_found = 1'b1;
          disp_idx   = 3'(j);
        end
      end
    end
`else
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (!disp_found && avail[i]) begin
        disp_found = 1'b1;
        disp_idx   = 3'(i);
      end
    end
`endif
  end

  always_comb begin : dispatch_decode
    disp_onehot = '0;
    for (int unsigned j = 0; j < NUM_UNITS; j++) begin
      disp_onehot[j] = disp_found && (disp_idx == 3'(j));
    end
  end

  always_comb begin : result_pick
    res_any     = 1'b0;
    res_sel     = '0;
    res_sel_tag = '0;
    for (int unsigned j = 0; j < NUM_UNITS; j++) begin
      if (!res_any && slot_full[j]) begin
        res_any     = 1'b1;
        res_sel     = 3'(j);
        res_sel_tag = slot_tag[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy        <= '0;
      slot_full   <= '0;
      start_r     <= '0;
      unit_tag_r  <= '0;
      res_valid_r <= 1'b0;
      res_tag_r   <= '0;
      res_unit_r  <= '0;
      err_r       <= 1'b0;
      for (int unsigned k = 0; k < NUM_UNITS; k++) begin
        run_tag[k]  <= '0;
        slot_tag[k] <= '0;
      end
`ifdef MUL_DISPATCH_RR_EN
      rr_ptr <= '0;
`endif
    end else begin
      start_r <= accept ? disp_onehot : '0;
      if (accept) unit_tag_r <= job_tag;

      // A unit taking a start is never busy, so it cannot see a legal done this edge.
      for (int unsigned k = 0; k < NUM_UNITS; k++) begin
        if (accept && disp_onehot[k]) begin
          busy[k]    <= 1'b1;
          run_tag[k] <= job_tag;
        end else if (unit_done[k] && busy[k]) begin
          busy[k]      <= 1'b0;
          slot_full[k] <= 1'b1;
          slot_tag[k]  <= run_tag[k];
        end
        if (load && res_any && res_sel == 3'(k)) slot_full[k] <= 1'b0;
      end

      if (|(unit_done & ~busy)) err_r <= 1'b1;

      if (load) begin
        res_valid_r <= res_any;
        if (res_any) begin
          res_tag_r  <= res_sel_tag;
          res_unit_r <= res_sel;
        end
      end

`ifdef MUL_DISPATCH_RR_EN
      if (accept) rr_ptr <= (disp_idx == 3'(NUM_UNITS - 1)) ? 3'd0 : disp_idx + 3'd1;
`endif
    end
  end

  // Reset also masks a start launched by the acceptance just before it.
  assign unit_start = reset ? '0 : start_r;
  assign unit_tag   = unit_tag_r;
  assign res_valid  = res_valid_r;
  assign res_tag    = res_tag_r;
  assign res_unit   = res_unit_r;
  assign err        = err_r;
  assign idle       = ~|busy && ~|slot_full && !res_valid_r && ~|start_r;

endmodule
